tpu_out_engine: RTL and testbench
=================================

# tpu_out_engine

Parametrised output stage for the TPU datapath. It accepts raw accumulator rows from the systolic array through a valid/ready handshake and requantises each lane with a programmable rounding right-shift. Each row is written to one of NUM_SETS output SRAM channels with auto-incrementing addresses. It generalises the fixed three-bank (a/b/c) write-out path to any set count, accumulator width and depth, and adds start/busy/done framing and back-pressure.

## Interface
- ARRAY_SIZE, 8, lanes per row
- ACC_WIDTH, 21, signed accumulator width per lane
- OUTPUT_DATA_WIDTH, 16, signed output width per lane
- NUM_SETS, 3, output SRAM channels; legal range 1..8
- ROWS_PER_SET, 8, rows written to each set; must be ≤ 2^ADDR_WIDTH
- ADDR_WIDTH, 6, SRAM write-address width

Ports:
- clk  in  1  sole clock; all logic on the rising edge
- srst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle job start; honoured only in IDLE
- shift  in  5  right-shift amount; sampled on an accepted start
- in_valid  in  1  in_data holds a valid row
- in_data  in  ARRAY_SIZE*ACC_WIDTH  lane i is at [i*ACC_WIDTH +: ACC_WIDTH]
- in_ready  out  1  engine accepts a row this cycle
- sram_write_enable  out  NUM_SETS  one-hot, active-high; bit s writes set s
- sram_wdata  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  shared write data; lane i at [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]
- sram_waddr  out  ADDR_WIDTH  shared write address
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at job end

## Operation
State machine states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start:
  - shift_q is loaded with min(shift, ACC_WIDTH-1).
  - set_cnt and row_cnt are cleared to 0.
- RUN:
  - in_ready is 1.
  - A beat is accepted when in_valid && in_ready.
  - Each accepted beat is tagged with (set_cnt, row_cnt).
  - row_cnt increments on each beat. At ROWS_PER_SET-1 it wraps to 0 and set_cnt increments.
- RUN → DRAIN on the beat tagged (NUM_SETS-1, ROWS_PER_SET-1). in_ready is 0 from the next cycle.
- DRAIN holds until both pipeline stages are empty, then goes to DONE.
- DONE lasts 1 cycle with done=1, then returns to IDLE.
- Quantise, per lane:
  - r = acc + (shift_q>0 ? 1<<(shift_q-1) : 0), evaluated at ACC_WIDTH+1 bits (round half up).
  - q = r >>> shift_q (arithmetic shift).
  - q is narrowed to OUTPUT_DATA_WIDTH as set by the Configuration section.
- Pipeline:
  - Stage 1 registers the accepted row and its tag.
  - Stage 2 registers the quantised row and drives sram_write_enable[set]=1, sram_waddr=row and sram_wdata.
  - When a stage is empty, its write-enable bit is 0. wdata and waddr then hold their last values.
- Boundary conditions:
  - start outside IDLE is ignored.
  - in_valid while in_ready=0 is ignored; nothing is stored.
  - start in the DONE cycle is ignored.
  - in_valid gaps in RUN create bubbles. No write is issued for a bubble.

## Timing
- Reset values (cycle after srst high): state=IDLE; in_ready=0, sram_write_enable=0, sram_wdata=0, sram_waddr=0, busy=0, done=0.
- srst mid-job aborts the job at that edge and discards pipeline contents. No further writes occur and done is not pulsed.
- srst has priority over start.
- Latency: a beat accepted at edge N appears on the write outputs between edges N+2 and N+3 (2 cycles).
- The last write occurs 2 cycles after the last accepted beat. done pulses in the cycle after the last write-enable.
- in_ready is 1 in the cycle after an accepted start. The minimum job length is NUM_SETS*ROWS_PER_SET+4 cycles from start to done.
- Throughput: 1 row/cycle; there is no internal stall.

## Configuration
- TPU_OUT_SAT_EN defined: q saturates to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1].
- TPU_OUT_SAT_EN undefined: q is truncated to its low OUTPUT_DATA_WIDTH bits (two's-complement wrap).
- Rounding and all timing are identical in both builds.

## Test plan
- Defaults, shift=0: stream 24 rows with lane i = row*8+i, in_valid held high.
  - 24 writes occur: set 0 addr 0..7, then set 1, then set 2.
  - Output values equal the inputs.
  - done pulses exactly 28 cycles after start.
- shift=4, lanes {23, 24, -24, -25, 8, 7, 0, -8}:
  - Output is {1, 2, -1, -2, 1, 0, 0, 0}, which checks round half up.
- TPU_OUT_SAT_EN, shift=0, lanes {40000, -40000, 32767, -32768, …}:
  - Output is {32767, -32768, 32767, -32768, …}.
  - Without the macro: {-25536, 25536, 32767, -32768, …}.
- Toggle in_valid every other cycle:
  - Writes are spaced 2 cycles apart; no write-enable is asserted on bubble cycles; addresses stay contiguous.
- Assert srst after 10 accepted rows:
  - Next cycle all outputs are 0 and done never pulses.
  - A fresh start then writes from set 0 addr 0.
- start pulsed during RUN and in the DONE cycle:
  - Both are ignored; set and row counters are unaffected.

Source files
------------

// File: rtl/tpu_out_engine_if.sv
// ---------------------------------------------------------------------------
// tpu_out_engine_if
//
// Purpose: bundles the row-input stream and the SRAM write-out bus of the
// TPU output engine so a single port carries the whole datapath boundary.
//
// Handshake: a row transfers on a rising clk edge where in_valid and in_ready
// are both 1. in_valid/in_data come from the array side. in_ready comes from
// the engine and does not depend combinationally on in_valid. in_valid may be
// raised or dropped freely; nothing is stored while in_ready is 0.
//
// Signals:
//   in_valid           row on in_data is valid
//   in_data            ARRAY_SIZE lanes of ACC_WIDTH signed accumulators
//   in_ready           engine accepts a row this cycle
//   sram_write_enable  one-hot write strobe, bit s writes set s
//   sram_wdata         ARRAY_SIZE lanes of OUTPUT_DATA_WIDTH signed outputs
//   sram_waddr         shared write address
//
// Modports: slave = engine side, master = array/SRAM environment side.
// ---------------------------------------------------------------------------
interface tpu_out_engine_if #(
  parameter int ARRAY_SIZE        = 8,
  parameter int ACC_WIDTH         = 21,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int NUM_SETS          = 3,
  parameter int ADDR_WIDTH        = 6
);
  logic                                    in_valid;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         in_data;
  logic                                    in_ready;
  logic [NUM_SETS-1:0]                     sram_write_enable;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata;
  logic [ADDR_WIDTH-1:0]                   sram_waddr;

  modport slave (
    input  in_valid, in_data,
    output in_ready, sram_write_enable, sram_wdata, sram_waddr
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, sram_write_enable, sram_wdata, sram_waddr
  );
endinterface

// File: rtl/tpu_out_engine.sv
// ---------------------------------------------------------------------------
// tpu_out_engine
//
// Purpose: output stage of the TPU datapath. Accepts accumulator rows, applies
// a rounding (half-up) arithmetic right shift per lane, narrows each lane to
// OUTPUT_DATA_WIDTH and writes the row to one of NUM_SETS SRAM channels with
// auto-incrementing addresses. Rows fill set 0 addresses 0..ROWS_PER_SET-1,
// then set 1, and so on. A job is framed by start / busy / done.
//
// Optional feature macro: TPU_OUT_SAT_EN
//   defined   -> lanes saturate to the signed OUTPUT_DATA_WIDTH range
//   undefined -> lanes keep their low OUTPUT_DATA_WIDTH bits (wrap)
//
// Ports:
//   clk        sole clock, rising edge
//   srst       synchronous active-high reset, priority over everything
//   start      single-cycle job start, honoured only in IDLE
//   shift      right-shift amount, captured (clamped to ACC_WIDTH-1) on start
//   bus        tpu_out_engine_if.slave: row stream in, SRAM write bus out
//   busy       high from the cycle after an accepted start until done
//   done       single-cycle pulse at job end
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module tpu_out_engine #(
  parameter int ARRAY_SIZE        = 8,
  parameter int ACC_WIDTH         = 21,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int NUM_SETS          = 3,
  parameter int ROWS_PER_SET      = 8,
  parameter int ADDR_WIDTH        = 6
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [4:0]            shift,
  tpu_out_engine_if.slave       bus,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int QW    = ACC_WIDTH + 1;        // rounding headroom
  localparam int OW    = OUTPUT_DATA_WIDTH;
  localparam int DW    = ARRAY_SIZE * ACC_WIDTH;
  localparam int WW    = ARRAY_SIZE * OW;

  localparam logic [SET_W-1:0]      LAST_SET = SET_W'(NUM_SETS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS_PER_SET - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic [4:0]             shift_q;
  logic [SET_W-1:0]       set_cnt_q;
  logic [ADDR_WIDTH-1:0]  row_cnt_q;

  // Stage 1: accepted row and its (set,row) tag
  logic                   s1_valid_q;
  logic [DW-1:0]          s1_data_q;
  logic [SET_W-1:0]       s1_set_q;
  logic [ADDR_WIDTH-1:0]  s1_row_q;

  // Stage 2: write-out registers
  logic [NUM_SETS-1:0]    we_q;
  logic [WW-1:0]          wdata_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;

  logic                   accept;
  logic                   last_beat;
  logic [4:0]             shift_clamped;

  assign accept        = in_ready_q && bus.in_valid;
  assign last_beat     = accept && (set_cnt_q == LAST_SET) && (row_cnt_q == LAST_ROW);
  assign shift_clamped = (int'(shift) > ACC_WIDTH - 1) ? 5'(ACC_WIDTH - 1) : shift;

  // -------------------------------------------------------------------------
  // Requantisation of the stage-1 row
  // -------------------------------------------------------------------------
  logic [WW-1:0]          q_row;
  logic [NUM_SETS-1:0]    we_row;
  logic signed [QW-1:0]   rnd_v;
  logic signed [QW-1:0]   ext_v;
  logic signed [QW-1:0]   r_v;
  logic signed [QW-1:0]   q_v;
  logic [QW-OW:0]         hi_v;
  logic [OW-1:0]          n_v;

  always_comb begin
    q_row = '0;
    ext_v = '0;
    r_v   = '0;
    q_v   = '0;
    hi_v  = '0;
    n_v   = '0;
    rnd_v = (shift_q != 5'd0) ? (QW'(1) <<< (shift_q - 5'd1)) : '0;
    for (int l = 0; l < ARRAY_SIZE; l++) begin
      ext_v = {s1_data_q[l*ACC_WIDTH + ACC_WIDTH - 1], s1_data_q[l*ACC_WIDTH +: ACC_WIDTH]};
      r_v   = ext_v + rnd_v;
      q_v   = r_v >>> shift_q;
      // Bits from the output sign position upward must all agree for q to
      // fit in OW bits without loss.
      hi_v  = q_v[QW-1:OW-1];
`ifdef TPU_OUT_SAT_EN
      if ((&hi_v) || !(|hi_v)) begin
        n_v = q_v[OW-1:0];
      end else if (q_v[QW-1]) begin
        n_v = {1'b1, {(OW-1){1'b0}}};
      end else begin
        n_v = {1'b0, {(OW-1){1'b1}}};
      end
`else
      n_v = q_v[OW-1:0];
`endif
      q_row[l*OW +: OW] = n_v;
    end
  end

  always_comb begin
    we_row = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      we_row[s] = (s1_set_q == SET_W'(s));
    end
  end

  // -------------------------------------------------------------------------
  // FSM, counters and pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_q    <= '0;
      set_cnt_q  <= '0;
      row_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_set_q   <= '0;
      s1_row_q   <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= bus.in_data;
        s1_set_q  <= set_cnt_q;
        s1_row_q  <= row_cnt_q;
        if (row_cnt_q == LAST_ROW) begin
          row_cnt_q <= '0;
          set_cnt_q <= set_cnt_q + SET_W'(1);
        end else begin
          row_cnt_q <= row_cnt_q + ADDR_WIDTH'(1);
        end
      end

      // Empty stage 1 is a bubble: no strobe, data/address keep last value.
      we_q <= s1_valid_q ? we_row : '0;
      if (s1_valid_q) begin
        wdata_q <= q_row;
        waddr_q <= s1_row_q;
      end

      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            shift_q    <= shift_clamped;
            set_cnt_q  <= '0;
            row_cnt_q  <= '0;
          end
        end
        S_RUN: begin
          if (last_beat) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Stage 1 empty means stage 2 is issuing the final write now, so
          // both stages are empty in the next cycle, which is the DONE cycle.
          if (!s1_valid_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.sram_write_enable = we_q;
  assign bus.sram_wdata        = wdata_q;
  assign bus.sram_waddr        = waddr_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_tpu_out_engine.sv
module tb_tpu_out_engine;
  localparam int AS    = 8;
  localparam int ACC_W = 21;
  localparam int OUT_W = 16;
  localparam int NSETS = 3;
  localparam int RPS   = 8;
  localparam int AW    = 6;
  localparam int ROWS  = NSETS * RPS;
  localparam int EW    = 3 + AW + AS * OUT_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] shift = '0;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tpu_out_engine_if #(
    .ARRAY_SIZE(AS), .ACC_WIDTH(ACC_W), .OUTPUT_DATA_WIDTH(OUT_W),
    .NUM_SETS(NSETS), .ADDR_WIDTH(AW)
  ) bus_if ();

  tpu_out_engine #(
    .ARRAY_SIZE(AS), .ACC_WIDTH(ACC_W), .OUTPUT_DATA_WIDTH(OUT_W),
    .NUM_SETS(NSETS), .ROWS_PER_SET(RPS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .shift(shift),
    .bus(bus_if), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  start_cyc = 0;
  int  done_before = 0;
  bit  spacing_on = 0;
  bit  have_last = 0;
  int  last_wr = 0;
  int  fix_in[8];
  int  fix_exp[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: round half up, floor-divide by 2^s, then narrow.
  function automatic logic [15:0] ref_q(input longint acc, input int sh);
    int     s;
    longint d, r, q;
    s = (sh > ACC_W - 1) ? ACC_W - 1 : sh;
    d = longint'(1) << s;
    r = acc + ((s > 0) ? d / 2 : longint'(0));
    q = r / d;
    if ((r % d != 0) && (r < 0)) q = q - 1;
`ifdef TPU_OUT_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`endif
    return 16'(q);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    logic [2:0]    set_idx;
    if (bus_if.sram_write_enable != '0) begin
      set_idx = '0;
      for (int s = 0; s < NSETS; s++)
        if (bus_if.sram_write_enable[s]) set_idx = 3'(s);
      chk("we_onehot", {255'd0, $onehot(bus_if.sram_write_enable)}, 256'd1);
      a = {set_idx, bus_if.sram_waddr, bus_if.sram_wdata};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected no write (t=%0t)", a, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_set_addr_data", a, e);
      end
      if (spacing_on) begin
        if (have_last) chk("write_spacing", cyc - last_wr, 2);
        have_last = 1;
        last_wr   = cyc;
      end
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_start(input int sh);
    @(posedge clk); #1;
    shift       = 5'(sh);
    start       = 1'b1;
    start_cyc   = cyc;
    done_before = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // vmode: 0 always valid, 1 toggle, 2 random gaps
  // dmode: 0 ramp row*8+i, 1 random, 2 fixed lanes with literal expectations
  task automatic stream(input int n, input int sh, input int vmode, input int dmode,
                        input int start_beat);
    int  acc_cnt = 0;
    int  budget  = 0;
    bit  v;
    int  val;
    logic [20:0]          raw;
    logic [AS*ACC_W-1:0]  d;
    logic [AS*OUT_W-1:0]  e;
    while (acc_cnt < n && budget < 2000) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < AS; i++) begin
        if (dmode == 0) begin
          val = acc_cnt * 8 + i;
          e[i*OUT_W +: OUT_W] = ref_q(longint'(val), sh);
        end else if (dmode == 1) begin
          raw = 21'($urandom);
          val = int'($signed(raw));
          e[i*OUT_W +: OUT_W] = ref_q(longint'(val), sh);
        end else begin
          val = fix_in[i];
          e[i*OUT_W +: OUT_W] = 16'(fix_exp[i]);
        end
        d[i*ACC_W +: ACC_W] = 21'(val);
      end
      bus_if.in_valid = v;
      bus_if.in_data  = d;
      start = (start_beat >= 0 && acc_cnt == start_beat);
      @(negedge clk);
      if (budget == 0) begin
        chk("ready_after_start", {255'd0, bus_if.in_ready}, 256'd1);
        chk("busy_after_start", {255'd0, busy}, 256'd1);
      end
      if (v && bus_if.in_ready) begin
        exp_q.push_back({3'(acc_cnt / RPS), 6'(acc_cnt % RPS), e});
        acc_cnt++;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus_if.in_valid = 1'b0;
    start = 1'b0;
    if (acc_cnt < n) chk("stream_accept_timeout", acc_cnt, n);
  endtask

  task automatic wait_done(input int exp_len, input bit start_in_done);
    int b = 0;
    bit seen = 0;
    while (!seen && b < 300) begin
      @(negedge clk); #1;
      seen = done;
      b++;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (exp_len > 0) chk("job_length", cyc - start_cyc + 1, exp_len);
      chk("all_written_at_done", exp_q.size(), 0);
      if (start_in_done) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      chk("done_single_pulse", {255'd0, done}, 256'd0);
      chk("done_count", done_cnt, done_before + 1);
      if (start_in_done) begin
        chk("start_in_done_state", dbg_state, 0);
        chk("start_in_done_ready", {255'd0, bus_if.in_ready}, 256'd0);
        chk("start_in_done_busy", {255'd0, busy}, 256'd0);
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, {255'd0, bus_if.in_ready}, 256'd0);
    chk({tag, "_we"}, bus_if.sram_write_enable, 0);
    chk({tag, "_wdata"}, bus_if.sram_wdata, 0);
    chk({tag, "_waddr"}, bus_if.sram_waddr, 0);
    chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
    chk({tag, "_done"}, {255'd0, done}, 256'd0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sh;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");

    // ramp, shift 0: outputs equal inputs, minimum job length
    send_start(0);
    stream(ROWS, 0, 0, 0, -1);
    wait_done(ROWS + 4, 0);

    // round half up
    fix_in  = '{23, 24, -24, -25, 8, 7, 0, -8};
    fix_exp = '{1, 2, -1, -2, 1, 0, 0, 0};
    send_start(4);
    stream(ROWS, 4, 0, 2, -1);
    wait_done(ROWS + 4, 0);

    // narrowing at shift 0
    fix_in  = '{40000, -40000, 32767, -32768, 0, 1, -1, 100};
`ifdef TPU_OUT_SAT_EN
    fix_exp = '{32767, -32768, 32767, -32768, 0, 1, -1, 100};
`else
    fix_exp = '{-25536, 25536, 32767, -32768, 0, 1, -1, 100};
`endif
    send_start(0);
    stream(ROWS, 0, 0, 2, -1);
    wait_done(ROWS + 4, 0);

    // toggling in_valid: writes every 2 cycles, no bubble writes
    sh = $urandom_range(0, 12);
    spacing_on = 1;
    have_last  = 0;
    send_start(sh);
    stream(ROWS, sh, 1, 1, -1);
    wait_done(-1, 0);
    spacing_on = 0;

    // abort after 10 accepted rows
    send_start(0);
    stream(10, 0, 0, 0, -1);
    srst = 1'b1;
    @(negedge clk); #1;
    chk("abort_pending_rows", exp_q.size(), 1);
    @(posedge clk); #1;
    exp_q.delete();
    srst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("abort");
    repeat (6) @(negedge clk);
    #1 chk("abort_no_done", done_cnt, done_before);

    // fresh job after abort starts from set 0 addr 0
    send_start(0);
    stream(ROWS, 0, 0, 0, -1);
    wait_done(ROWS + 4, 0);

    // start during RUN and in the DONE cycle
    send_start(3);
    stream(ROWS, 3, 0, 1, 7);
    wait_done(ROWS + 4, 1);

    // random jobs, random gaps, shifts beyond the clamp
    for (int j = 0; j < 3; j++) begin
      sh = $urandom_range(0, 31);
      send_start(sh);
      stream(ROWS, sh, 2, 1, -1);
      wait_done(-1, 0);
    end

    repeat (4) @(negedge clk);
    #1 chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $fatal(1);
  end

endmodule
